alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_pkg.sv | 71 +++++++
 rtl/alu_regfile.sv | 41 ++++
 rtl/alu_issue_stage.sv | 131 +++++++++++++
 tb/tb_alu_issue_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_pkg : shared ALU opcodes, instruction field layout and widths
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package alu_issue_pkg;

  localparam int unsigned NREG      = 8;
  localparam int unsigned C_DATA_W  = 8;
  localparam int unsigned C_RADDR_W = 3;
  localparam int unsigned C_INSTR_W = 20;
  localparam int unsigned C_CNT_W   = 3;
  localparam int unsigned C_OP_W    = 4;

  localparam int unsigned C_OP_MSB   = 19;
  localparam int unsigned C_OP_LSB   = 16;
  localparam int unsigned C_RD_MSB   = 15;
  localparam int unsigned C_RD_LSB   = 13;
  localparam int unsigned C_RS_MSB   = 12;
  localparam int unsigned C_RS_LSB   = 10;
  localparam int unsigned C_RSVD_BIT = 9;
  localparam int unsigned C_IMM_EN   = 8;
  localparam int unsigned C_IMM_MSB  = 7;
  localparam int unsigned C_IMM_LSB  = 0;
  localparam int unsigned C_RT_MSB   = 2;
  localparam int unsigned C_RT_LSB   = 0;
  localparam int unsigned C_CNT_MSB  = 2;
  localparam int unsigned C_CNT_LSB  = 0;

  typedef enum logic [C_OP_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_ADC  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_SBC  = 4'b0011,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_ANDN = 4'b0111,
    OP_SHL  = 4'b1000,
    OP_SHR  = 4'b1001,
    OP_ROL  = 4'b1011
  } alu_op_e;

  function automatic logic op_is_legal(input logic [C_OP_W-1:0] op);
    logic legal;
    legal = 1'b0;
    case (alu_op_e'(op))
      OP_ADD, OP_ADC, OP_SUB, OP_SBC,
      OP_AND, OP_OR, OP_XOR, OP_ANDN,
      OP_SHL, OP_SHR, OP_ROL: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Logic ops (01xx) leave the carry flag untouched.
  function automatic logic op_writes_c(input logic [C_OP_W-1:0] op);
    logic wc;
    wc = 1'b0;
    case (alu_op_e'(op))
      OP_ADD, OP_ADC, OP_SUB, OP_SBC,
      OP_SHL, OP_SHR, OP_ROL: wc = 1'b1;
      default:                wc = 1'b0;
    endcase
    return wc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile : 2R/1W general register file with R0 hard-wired to zero
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int unsigned NREG = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic [C_RADDR_W-1:0] i_waddr,
  input  logic [C_DATA_W-1:0]  i_wdata,
  input  logic [C_RADDR_W-1:0] i_raddr_a,
  output logic [C_DATA_W-1:0]  o_rdata_a,
  input  logic [C_RADDR_W-1:0] i_raddr_b,
  output logic [C_DATA_W-1:0]  o_rdata_b,
  input  logic [C_RADDR_W-1:0] i_raddr_dbg,
  output logic [C_DATA_W-1:0]  o_rdata_dbg
);

  logic [C_DATA_W-1:0] r_regs [1:NREG-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a   = (i_raddr_a   == '0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b   = (i_raddr_b   == '0) ? '0 : r_regs[i_raddr_b];
  assign o_rdata_dbg = (i_raddr_dbg == '0) ? '0 : r_regs[i_raddr_dbg];

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage : operand issue, forwarding and writeback around an external ALU
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int unsigned NREG = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [C_INSTR_W-1:0] instr_i,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  output logic [C_DATA_W-1:0]  rs_o,
  output logic [C_DATA_W-1:0]  op2_o,
  output logic [C_CNT_W-1:0]   count_o,
  output logic                 carry_o,
  output logic [C_OP_W-1:0]    alu_op_o,
  input  logic [C_DATA_W-1:0]  res_i,
  input  logic                 carry_i,
  input  logic                 zero_i,
  output logic                 flag_c_o,
  output logic                 flag_z_o,
  output logic                 illegal_o,
  input  logic [C_RADDR_W-1:0] dbg_addr_i,
  output logic [C_DATA_W-1:0]  dbg_data_o
);

  logic [C_OP_W-1:0]    w_op;
  logic [C_RADDR_W-1:0] w_rd, w_rs, w_rt;
  logic [C_CNT_W-1:0]   w_cnt;
  logic                 w_imm_en;
  logic [C_DATA_W-1:0]  w_imm8;
  logic                 w_unused_rsvd;

  assign w_op          = instr_i[C_OP_MSB:C_OP_LSB];
  assign w_rd          = instr_i[C_RD_MSB:C_RD_LSB];
  assign w_rs          = instr_i[C_RS_MSB:C_RS_LSB];
  assign w_rt          = instr_i[C_RT_MSB:C_RT_LSB];
  assign w_cnt         = instr_i[C_CNT_MSB:C_CNT_LSB];
  assign w_imm_en      = instr_i[C_IMM_EN];
  assign w_imm8        = instr_i[C_IMM_MSB:C_IMM_LSB];
  assign w_unused_rsvd = instr_i[C_RSVD_BIT];

  logic                 r_ex_valid;
  logic [C_RADDR_W-1:0] r_ex_rd;
  logic                 r_flag_c, r_flag_z;
  logic [C_DATA_W-1:0]  r_rs, r_op2;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_carry;
  logic [C_OP_W-1:0]    r_alu_op;

  logic                 w_accept, w_ex_legal, w_ex_wr_c, w_fwd_rs, w_fwd_rt;
  logic [C_DATA_W-1:0]  w_rf_rs, w_rf_rt, w_rs_val, w_op2_val;
  logic                 w_carry_val;

  // The stage never stalls: it is ready exactly when out of reset.
  assign instr_ready_o = rst_ni;
  assign w_accept      = instr_valid_i & instr_ready_o;

  assign w_ex_legal  = r_ex_valid & op_is_legal(r_alu_op);
  assign w_ex_wr_c   = w_ex_legal & op_writes_c(r_alu_op);
  assign w_fwd_rs    = w_ex_legal && (r_ex_rd != '0) && (r_ex_rd == w_rs);
  assign w_fwd_rt    = w_ex_legal && (r_ex_rd != '0) && (r_ex_rd == w_rt);
  assign w_rs_val    = w_fwd_rs ? res_i : w_rf_rs;
  assign w_op2_val   = w_imm_en ? w_imm8 : (w_fwd_rt ? res_i : w_rf_rt);
  assign w_carry_val = w_ex_wr_c ? carry_i : r_flag_c;

  alu_regfile #(
    .NREG (NREG)
  ) u_regfile (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .i_we        (w_ex_legal),
    .i_waddr     (r_ex_rd),
    .i_wdata     (res_i),
    .i_raddr_a   (w_rs),
    .o_rdata_a   (w_rf_rs),
    .i_raddr_b   (w_rt),
    .o_rdata_b   (w_rf_rt),
    .i_raddr_dbg (dbg_addr_i),
    .o_rdata_dbg (dbg_data_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ex_valid <= 1'b0;
      r_ex_rd    <= '0;
      r_rs       <= '0;
      r_op2      <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_alu_op   <= '0;
    end else begin
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_ex_rd  <= w_rd;
        r_rs     <= w_rs_val;
        r_op2    <= w_op2_val;
        r_cnt    <= w_cnt;
        r_carry  <= w_carry_val;
        r_alu_op <= w_op;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
    end else if (w_ex_legal) begin
      r_flag_z <= zero_i;
      if (w_ex_wr_c) r_flag_c <= carry_i;
    end
  end

  assign rs_o      = r_rs;
  assign op2_o     = r_op2;
  assign count_o   = r_cnt;
  assign carry_o   = r_carry;
  assign alu_op_o  = r_alu_op;
  assign flag_c_o  = r_flag_c;
  assign flag_z_o  = r_flag_z;
  assign illegal_o = r_ex_valid & ~op_is_legal(r_alu_op);

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage : directed + random checks against a sequential ISA model
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_stage;

  localparam logic [3:0] ADD = 4'b0000, ADC = 4'b0001, AND_ = 4'b0100;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [19:0] instr_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [7:0]  rs_o, op2_o;
  logic [2:0]  count_o;
  logic        carry_o;
  logic [3:0]  alu_op_o;
  logic [7:0]  res_i;
  logic        carry_i, zero_i;
  logic        flag_c_o, flag_z_o, illegal_o;
  logic [2:0]  dbg_addr_i = '0;
  logic [7:0]  dbg_data_o;

  always #5 clk = ~clk;

  alu_issue_stage #(.NREG(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .rs_o(rs_o), .op2_o(op2_o), .count_o(count_o),
    .carry_o(carry_o), .alu_op_o(alu_op_o), .res_i(res_i), .carry_i(carry_i),
    .zero_i(zero_i), .flag_c_o(flag_c_o), .flag_z_o(flag_z_o), .illegal_o(illegal_o),
    .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o)
  );

  // Bench-side ALU: returns {carry, result}.
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic [2:0] n,
                                       input logic ci);
    logic [8:0] t;
    t = '0;
    case (op)
      4'd0:  t = {1'b0, a} + {1'b0, b};
      4'd1:  t = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      4'd2:  t = {1'b0, a} - {1'b0, b};
      4'd3:  t = {1'b0, a} - {1'b0, b} - {8'd0, ci};
      4'd4:  t = {1'b0, a & b};
      4'd5:  t = {1'b0, a | b};
      4'd6:  t = {1'b0, a ^ b};
      4'd7:  t = {1'b0, a & ~b};
      4'd8:  t = {1'b0, a} << n;
      4'd9:  begin t[7:0] = a >> n; t[8] = (n == 3'd0) ? 1'b0 : a[n - 3'd1]; end
      4'd11: begin t[7:0] = (a << n) | (a >> (4'd8 - {1'b0, n})); t[8] = t[0]; end
      default: t = '0;
    endcase
    return t;
  endfunction

  logic [8:0] alu_t;
  assign alu_t   = alu_f(alu_op_o, rs_o, op2_o, count_o, carry_o);
  assign res_i   = alu_t[7:0];
  assign carry_i = alu_t[8];
  assign zero_i  = (alu_t[7:0] == 8'd0);

  // Architectural model: instructions complete one after another in order.
  logic [7:0] m_reg [8];
  logic       m_c, m_z;
  logic [7:0] e_rs, e_op2;
  logic [2:0] e_cnt;
  logic       e_carry;
  logic [3:0] e_op;
  int         n_vec = 0, n_err = 0;

  function automatic logic legal(input logic [3:0] op);
    return !(op == 4'b1010 || op[3:2] == 2'b11);
  endfunction

  function automatic logic upd_c(input logic [3:0] op);
    return (op[3:2] == 2'b00) || (op[3:2] == 2'b10);
  endfunction

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic ie,
                                     input logic [7:0] imm);
    return {op, rd, rs, 1'b0, ie, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_c = 0; m_z = 0; e_rs = '0; e_op2 = '0; e_cnt = '0; e_carry = 0; e_op = '0;
  endtask

  task automatic issue(input logic v, input logic [19:0] ins, input logic [2:0] da);
    logic [8:0] r;
    @(negedge clk);
    instr_valid_i = v; instr_i = ins; dbg_addr_i = da;
    @(posedge clk); #1;
    if (v) begin
      e_op    = ins[19:16];
      e_rs    = m_reg[ins[12:10]];
      e_op2   = ins[8] ? ins[7:0] : m_reg[ins[2:0]];
      e_cnt   = ins[2:0];
      e_carry = m_c;
    end
    chk("ready", instr_ready_o, 1);
    chk("rs_o", rs_o, e_rs);
    chk("op2_o", op2_o, e_op2);
    chk("count_o", count_o, e_cnt);
    chk("carry_o", carry_o, e_carry);
    chk("alu_op_o", alu_op_o, e_op);
    chk("illegal_o", illegal_o, v && !legal(ins[19:16]));
    chk("flag_c", flag_c_o, m_c);
    chk("flag_z", flag_z_o, m_z);
    chk("dbg", dbg_data_o, m_reg[da]);
    if (v && legal(ins[19:16])) begin
      r = alu_f(e_op, e_rs, e_op2, e_cnt, e_carry);
      if (ins[15:13] != 3'd0) m_reg[ins[15:13]] = r[7:0];
      m_z = (r[7:0] == 8'd0);
      if (upd_c(e_op)) m_c = r[8];
    end
    instr_valid_i = 0;
  endtask

  initial begin
    logic [19:0] ins;
    logic        v;
    model_reset();
    #1;
    chk("rst_ready", instr_ready_o, 0);
    chk("rst_rs", rs_o, 0);
    chk("rst_op2", op2_o, 0);
    chk("rst_cnt", count_o, 0);
    chk("rst_carry", carry_o, 0);
    chk("rst_op", alu_op_o, 0);
    chk("rst_c", flag_c_o, 0);
    chk("rst_z", flag_z_o, 0);
    chk("rst_ill", illegal_o, 0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr_i = 3'(i); #1;
      chk("rst_dbg", dbg_data_o, 0);
    end
    @(negedge clk); @(negedge clk);
    rst_ni = 1;

    // R1 = R0 + 5
    issue(1, mk(ADD, 3'd1, 3'd0, 1, 8'h05), 3'd0);
    chk("add_rs", rs_o, 8'h00);
    chk("add_op2", op2_o, 8'h05);
    issue(0, '0, 3'd1);
    chk("add_r1", dbg_data_o, 8'h05);
    chk("add_z", flag_z_o, 0);
    chk("add_c", flag_c_o, 0);

    // R1 = 0xFF, R2 = R1 + R1 forwarded, then ADC with forwarded carry
    issue(1, mk(ADD, 3'd1, 3'd0, 1, 8'hFF), 3'd0);
    issue(1, mk(ADD, 3'd2, 3'd1, 0, 8'h01), 3'd0);
    chk("fwd_rs", rs_o, 8'hFF);
    chk("fwd_op2", op2_o, 8'hFF);
    issue(1, mk(ADC, 3'd3, 3'd0, 1, 8'hFF), 3'd2);
    chk("fwd_carry", carry_o, 1);
    chk("r2_fe", dbg_data_o, 8'hFE);
    chk("r2_c", flag_c_o, 1);
    issue(1, mk(AND_, 3'd4, 3'd0, 1, 8'h00), 3'd3);
    issue(0, '0, 3'd4);
    chk("and_keeps_c", flag_c_o, 1);

    // Illegal op to R4
    issue(1, mk(ADD, 3'd4, 3'd0, 1, 8'h33), 3'd0);
    issue(0, '0, 3'd4);
    issue(1, {4'b1100, 3'd4, 3'd1, 1'b0, 1'b1, 8'h00}, 3'd4);
    chk("ill_pulse", illegal_o, 1);
    issue(0, '0, 3'd4);
    chk("ill_once", illegal_o, 0);
    chk("ill_r4", dbg_data_o, 8'h33);
    chk("ill_c", flag_c_o, 0);
    chk("ill_z", flag_z_o, 0);

    // R0 write discarded, Z still updates
    issue(1, mk(ADD, 3'd0, 3'd0, 1, 8'h00), 3'd0);
    issue(0, '0, 3'd0);
    chk("r0_zero", dbg_data_o, 8'h00);
    chk("r0_z", flag_z_o, 1);
    issue(1, mk(ADD, 3'd0, 3'd1, 1, 8'h00), 3'd0);
    issue(1, mk(ADD, 3'd6, 3'd0, 0, 8'h00), 3'd0);
    chk("r0_nofwd", rs_o, 8'h00);

    // Reset in the writeback cycle of R5 = 7
    issue(1, mk(ADD, 3'd5, 3'd0, 1, 8'h07), 3'd5);
    #2 rst_ni = 0;
    #1;
    chk("mid_ready", instr_ready_o, 0);
    chk("mid_op2", op2_o, 0);
    chk("mid_op", alu_op_o, 0);
    chk("mid_c", flag_c_o, 0);
    chk("mid_z", flag_z_o, 0);
    @(posedge clk); #1;
    chk("mid_r5", dbg_data_o, 8'h00);
    chk("mid_ready2", instr_ready_o, 0);
    model_reset();
    @(negedge clk);
    rst_ni = 1;
    issue(0, '0, 3'd5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ins = 20'($urandom);
      v   = ($urandom_range(0, 9) != 0);
      issue(v, ins, 3'($urandom_range(0, 7)));
    end
    issue(0, '0, 3'd1);
    issue(0, '0, 3'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
